// File: rtl/intr_controller_if.sv
// CPU-side handshake bundle of the interrupt controller: request/ack/return plus
// the one-hot vector select.
interface intr_controller_if #(
  parameter int N_INTR = 8
);
  logic              cpu_intr;
  logic [N_INTR-1:0] intr_selec;
  logic              intr_active;
  logic              cpu_ack;
  logic              reti;

  modport master (
    output cpu_ack,
    output reti,
    input  cpu_intr,
    input  intr_selec,
    input  intr_active
  );

  modport slave (
    input  cpu_ack,
    input  reti,
    output cpu_intr,
    output intr_selec,
    output intr_active
  );
endinterface

// File: rtl/intr_controller.sv
// Eight-line edge-triggered interrupt controller with enable mask, fixed priority
// (bit 0 highest) and a REQ/SERVICE handshake. Optional macro INTR_SYNC_EN adds a
// two-flop synchronizer on every request line.
module intr_controller #(
  parameter int N_INTR = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_INTR-1:0] intr_req,
  input  logic              mask_we,
  input  logic [N_INTR-1:0] mask_in,
  intr_controller_if.slave  cpu,
  output logic [N_INTR-1:0] pending,
  output logic [N_INTR-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [N_INTR-1:0] ONE = N_INTR'(1);

  state_t            state_reg, state_next;
  logic [N_INTR-1:0] sel_reg, sel_next;
  logic [N_INTR-1:0] pending_reg, pending_next;
  logic [N_INTR-1:0] mask_reg;
  logic [N_INTR-1:0] req_q;
  logic [N_INTR-1:0] req_s;
  logic              cpu_intr_reg, active_reg;
  logic [N_INTR-1:0] edges, eligible, winner;

`ifdef INTR_SYNC_EN
  logic [N_INTR-1:0] sync1_reg, sync2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_INTR; gi++) begin : g_sync
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= intr_req[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  assign req_s = sync2_reg;
`else
  assign req_s = intr_req;
`endif

  assign edges    = req_s & ~req_q;
  assign eligible = pending_reg & mask_reg;
  // Isolate the lowest set bit: highest priority is bit 0.
  assign winner   = eligible & (~eligible + ONE);

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    pending_next = pending_reg | edges;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          sel_next   = winner;
          state_next = REQ;
        end
      end
      REQ: begin
        if (cpu.cpu_ack) begin
          // A fresh edge on the winner's own line survives the clear.
          pending_next = (pending_reg & ~sel_reg) | edges;
          state_next   = SERVICE;
        end
      end
      SERVICE: begin
        if (cpu.reti) begin
          sel_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        sel_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      pending_reg  <= '0;
      mask_reg     <= '0;
      req_q        <= '0;
      cpu_intr_reg <= 1'b0;
      active_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      pending_reg  <= pending_next;
      req_q        <= req_s;
      cpu_intr_reg <= (state_next == REQ);
      active_reg   <= (state_next == SERVICE);
      if (mask_we) begin
        mask_reg <= mask_in;
      end
    end
  end

  assign cpu.cpu_intr    = cpu_intr_reg;
  assign cpu.intr_active = active_reg;
  assign cpu.intr_selec  = sel_reg;
  assign pending         = pending_reg;
  assign mask            = mask_reg;

endmodule
